// File: rtl/fetch_unit_mo_pkg.sv
// fetch_unit_mo_pkg -- shared types and constants for the multi-outstanding
// fetch unit.
//   EXC_ADEL / EXC_NO_EX : exception codes carried with each fetched instruction
//   EX_ENTRY_DEF         : default exception handler entry
//   ibuf_entry_t         : one instruction-buffer entry {pc, inst, excode, badvaddr}
//   fetch_st_e           : fetch control states
package fetch_unit_mo_pkg;

    localparam logic [4:0]  EXC_ADEL     = 5'h04;
    localparam logic [4:0]  EXC_NO_EX    = 5'h1f;
    localparam logic [31:0] EX_ENTRY_DEF = 32'hbfc00380;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  excode;
        logic [31:0] badvaddr;
    } ibuf_entry_t;

    localparam int IBUF_W = $bits(ibuf_entry_t);

    // BOOT  : first cycle out of reset, no bus request yet
    // FETCH : normal issue
    // HALT  : misaligned PC already reported, wait for a redirect
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_st_e;

endpackage

// File: rtl/fetch_unit_mo_if.sv
// fetch_unit_mo_if -- inst-SRAM-like bus between the fetch unit and memory.
//   master : fetch unit (drives req/wr/size/wstrb/addr/wdata)
//   slave  : memory     (drives addr_ok/data_ok/rdata)
// Responses return in request order.
interface fetch_unit_mo_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );
endinterface

// File: rtl/fetch_unit_mo_ibuf.sv
// fetch_unit_mo_ibuf -- synchronous FIFO with flush (the fetch_ibuf block).
// Used both as the instruction buffer and as the pending-PC FIFO.
//   clk, resetn   : clock, async active-low reset
//   flush         : drop all entries (wins over push/pop)
//   push, din     : enqueue; accepted when not full, or full with a pop
//   pop, dout     : dequeue head; dout is the current head (registered storage)
//   full, empty, count : occupancy
module fetch_unit_mo_ibuf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_unit_mo.sv
// fetch_unit_mo -- IF stage with up to MAX_OUTSTANDING in-flight inst-SRAM
// requests and an IBUF_DEPTH instruction buffer decoupling fetch from ID.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched / perf_bubble counters.
//   clk, resetn                  : clock, async active-low reset
//   ds_allowin                   : ID accepts the buffer head this cycle
//   br_valid/br_taken/br_target  : branch resolution from ID
//   br_stall                     : hold new requests
//   ex_flush / eret_flush/cp0_epc: redirects committed in WB
//   fs_to_ds_*                   : head of the instruction buffer to ID
//   bus                          : inst-SRAM-like master port
module fetch_unit_mo
    import fetch_unit_mo_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'hbfc00000,
    parameter logic [31:0] EX_ENTRY        = EX_ENTRY_DEF,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          IBUF_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allowin,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        br_stall,
    input  logic        ex_flush,
    input  logic        eret_flush,
    input  logic [31:0] cp0_epc,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_to_ds_pc,
    output logic [31:0] fs_to_ds_inst,
    output logic [4:0]  fs_to_ds_excode,
    output logic [31:0] fs_to_ds_badvaddr,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubble,
`endif
    fetch_unit_mo_if.master bus
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(IBUF_DEPTH + 1);

    fetch_st_e   state, state_nxt;
    logic [31:0] fetch_pc, redirect_pc, pend_pc;
    logic [OW-1:0] outstanding, cancel_cnt;
    logic [CW-1:0] ibuf_count;
    logic        redirect, accept, resp_keep, adel_push;
    logic        ibuf_push, ibuf_pop, ibuf_full, ibuf_empty;
    logic        pend_full, pend_empty;
    ibuf_entry_t ibuf_din, ibuf_head;

    // Redirect priority: exception > ERET > taken branch.
    always_comb begin
        redirect    = 1'b1;
        redirect_pc = br_target;
        if (ex_flush)                  redirect_pc = EX_ENTRY;
        else if (eret_flush)           redirect_pc = cp0_epc;
        else if (br_valid && br_taken) redirect_pc = br_target;
        else                           redirect    = 1'b0;
    end

    // Issue only if every in-flight response is guaranteed an IBUF slot.
    assign bus.inst_sram_req = (state == ST_FETCH) && !br_stall && !redirect &&
                               !pend_full && (fetch_pc[1:0] == 2'b00) &&
                               (int'(ibuf_count) + int'(outstanding) < IBUF_DEPTH);
    assign bus.inst_sram_wr    = 1'b0;
    assign bus.inst_sram_size  = 2'b10;
    assign bus.inst_sram_wstrb = 4'h0;
    assign bus.inst_sram_addr  = {fetch_pc[31:2], 2'b00};
    assign bus.inst_sram_wdata = 32'h0;

    assign accept    = bus.inst_sram_req && bus.inst_sram_addr_ok;
    // Responses arriving in a redirect cycle are already stale.
    assign resp_keep = bus.inst_sram_data_ok && (cancel_cnt == '0) && !redirect;
    assign adel_push = (state == ST_FETCH) && (fetch_pc[1:0] != 2'b00) &&
                       pend_empty && !ibuf_full && !redirect;
    assign ibuf_push = resp_keep || adel_push;
    assign ibuf_pop  = !ibuf_empty && ds_allowin;

    always_comb begin
        if (resp_keep) ibuf_din = '{pc: pend_pc, inst: bus.inst_sram_rdata,
                                    excode: EXC_NO_EX, badvaddr: 32'h0};
        else           ibuf_din = '{pc: fetch_pc, inst: 32'h0,
                                    excode: EXC_ADEL, badvaddr: fetch_pc};
    end

    fetch_unit_mo_ibuf #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_pend (
        .clk(clk), .resetn(resetn), .flush(1'b0),
        .push(accept), .din(fetch_pc), .pop(bus.inst_sram_data_ok),
        .dout(pend_pc), .full(pend_full), .empty(pend_empty), .count(outstanding)
    );

    fetch_unit_mo_ibuf #(.WIDTH(IBUF_W), .DEPTH(IBUF_DEPTH)) u_ibuf (
        .clk(clk), .resetn(resetn), .flush(redirect),
        .push(ibuf_push), .din(ibuf_din), .pop(ibuf_pop),
        .dout(ibuf_head), .full(ibuf_full), .empty(ibuf_empty), .count(ibuf_count)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT:  state_nxt = ST_FETCH;
            ST_FETCH: if (adel_push) state_nxt = ST_HALT;
            ST_HALT:  if (redirect)  state_nxt = ST_FETCH;
            default:  state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_BOOT;
            fetch_pc   <= RESET_PC;
            cancel_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (redirect)    fetch_pc <= redirect_pc;
            else if (accept) fetch_pc <= fetch_pc + 32'd4;
            // Everything in flight at a redirect is stale, minus one
            // response consumed (and dropped) in this very cycle.
            if (redirect)
                cancel_cnt <= outstanding - OW'(bus.inst_sram_data_ok);
            else if (bus.inst_sram_data_ok && (cancel_cnt != '0))
                cancel_cnt <= cancel_cnt - OW'(1);
        end
    end

    assign fs_to_ds_valid    = !ibuf_empty;
    assign fs_to_ds_pc       = ibuf_empty ? 32'h0 : ibuf_head.pc;
    assign fs_to_ds_inst     = ibuf_empty ? 32'h0 : ibuf_head.inst;
    assign fs_to_ds_excode   = ibuf_empty ? 5'h0  : ibuf_head.excode;
    assign fs_to_ds_badvaddr = ibuf_empty ? 32'h0 : ibuf_head.badvaddr;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_fetched <= 32'h0;
            perf_bubble  <= 32'h0;
        end else begin
            if (ibuf_push)                 perf_fetched <= perf_fetched + 32'd1;
            if (ds_allowin && ibuf_empty)  perf_bubble  <= perf_bubble + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit_mo.sv
// tb_fetch_unit_mo -- self-checking bench for fetch_unit_mo.
// Reference model: the delivered stream must be consecutive words starting
// at the last redirect target (or RESET_PC), each carrying mem_word(pc);
// a misaligned target yields exactly one ADEL entry and no bus requests.
module tb_fetch_unit_mo;
    localparam logic [31:0] RESET_PC = 32'hbfc00000;
    localparam logic [31:0] EX_ENTRY = 32'hbfc00380;
    localparam int          MAX_OUT  = 2;
    localparam int          DEPTH    = 4;
    localparam logic [4:0]  ADEL     = 5'h04;
    localparam logic [4:0]  NO_EX    = 5'h1f;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ds_allowin = 1'b0, br_valid = 1'b0, br_taken = 1'b0, br_stall = 1'b0;
    logic        ex_flush = 1'b0, eret_flush = 1'b0;
    logic [31:0] br_target = 32'h0, cp0_epc = 32'h0;
    logic        fs_to_ds_valid;
    logic [31:0] fs_to_ds_pc, fs_to_ds_inst, fs_to_ds_badvaddr;
    logic [4:0]  fs_to_ds_excode;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_bubble;
`endif

    fetch_unit_mo_if bus();

    fetch_unit_mo #(.RESET_PC(RESET_PC), .EX_ENTRY(EX_ENTRY),
                    .MAX_OUTSTANDING(MAX_OUT), .IBUF_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .ds_allowin(ds_allowin),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
        .br_stall(br_stall), .ex_flush(ex_flush), .eret_flush(eret_flush),
        .cp0_epc(cp0_epc), .fs_to_ds_valid(fs_to_ds_valid),
        .fs_to_ds_pc(fs_to_ds_pc), .fs_to_ds_inst(fs_to_ds_inst),
        .fs_to_ds_excode(fs_to_ds_excode), .fs_to_ds_badvaddr(fs_to_ds_badvaddr),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched(perf_fetched), .perf_bubble(perf_bubble),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_fail = 0, cyc = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];
    int          dly_lo = 0, dly_hi = 0;
    logic [31:0] exp_pc = RESET_PC, exp_req_pc = RESET_PC;
    bit          adel_done = 0, want_first = 1;
    logic [31:0] first_pc = 32'h0, first_bad = 32'h0;
    logic [4:0]  first_exc = 5'h0;
    int          n_deliv = 0, n_acc = 0;
    logic        last_req = 1'b0, last_valid = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h13579bdf;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic observe();
        logic        redir;
        logic [31:0] tgt;
        redir = ex_flush || eret_flush || (br_valid && br_taken);
        tgt   = ex_flush ? EX_ENTRY : (eret_flush ? cp0_epc : br_target);
        last_req   = bus.inst_sram_req;
        last_valid = fs_to_ds_valid;

        if (redir || br_stall) chk("req_blocked", bus.inst_sram_req, 1'b0);
        if (bus.inst_sram_req) begin
            chk("req_outstanding", (q_addr.size() < MAX_OUT) ? 1 : 0, 1);
            chk("req_const", {bus.inst_sram_wr, bus.inst_sram_size, bus.inst_sram_wstrb,
                              bus.inst_sram_wdata}, {1'b0, 2'b10, 4'h0, 32'h0});
        end
        if (bus.inst_sram_data_ok) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        if (bus.inst_sram_req && bus.inst_sram_addr_ok) begin
            chk("req_addr", bus.inst_sram_addr, exp_req_pc);
            exp_req_pc += 32'd4;
            n_acc++;
            q_addr.push_back(bus.inst_sram_addr);
            q_due.push_back(cyc + 1 + int'($urandom_range(dly_hi, dly_lo)));
        end

        if (!fs_to_ds_valid) chk("idle_pc", fs_to_ds_pc, 32'h0);
        if (fs_to_ds_valid && ds_allowin) begin
            n_deliv++;
            if (want_first) begin
                first_pc = fs_to_ds_pc; first_exc = fs_to_ds_excode;
                first_bad = fs_to_ds_badvaddr; want_first = 0;
            end
            if (adel_done) chk("deliv_after_adel", fs_to_ds_valid, 1'b0);
            else if (exp_pc[1:0] != 2'b00) begin
                chk("adel_pc", fs_to_ds_pc, exp_pc);
                chk("adel_inst", fs_to_ds_inst, 32'h0);
                chk("adel_exc", fs_to_ds_excode, ADEL);
                chk("adel_bad", fs_to_ds_badvaddr, exp_pc);
                adel_done = 1;
            end else begin
                chk("deliv_pc", fs_to_ds_pc, exp_pc);
                chk("deliv_inst", fs_to_ds_inst, mem_word(exp_pc));
                chk("deliv_exc", fs_to_ds_excode, NO_EX);
                chk("deliv_bad", fs_to_ds_badvaddr, 32'h0);
                exp_pc += 32'd4;
            end
        end
        if (redir) begin
            exp_pc = tgt; exp_req_pc = tgt; adel_done = 0;
            want_first = 1; first_pc = 32'h0;
        end
    endtask

    // One bus cycle: inputs are already set (just after posedge).
    task automatic step();
        bus.inst_sram_data_ok = (q_addr.size() > 0) && (q_due[0] <= cyc);
        bus.inst_sram_rdata   = bus.inst_sram_data_ok ? mem_word(q_addr[0]) : $urandom;
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        cyc++;
        br_valid = 1'b0; br_taken = 1'b0; ex_flush = 1'b0; eret_flush = 1'b0;
    endtask

    initial begin
        int          base, base_acc, r;
        logic [31:0] tmp;
        bus.inst_sram_addr_ok = 1'b0;
        bus.inst_sram_data_ok = 1'b0;
        bus.inst_sram_rdata   = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", fs_to_ds_valid, 1'b0);
        chk("rst_pc", fs_to_ds_pc, 32'h0);
        chk("rst_inst", fs_to_ds_inst, 32'h0);
        chk("rst_exc", fs_to_ds_excode, 5'h0);
        chk("rst_bad", fs_to_ds_badvaddr, 32'h0);
        chk("rst_req", bus.inst_sram_req, 1'b0);
        resetn = 1'b1;

        // Streaming: addr_ok always, data_ok one cycle later.
        ds_allowin = 1'b1; bus.inst_sram_addr_ok = 1'b1;
        repeat (10) step();
        base = n_deliv;
        repeat (20) step();
        chk("stream_rate", n_deliv - base, 20);
        chk("boot_first_pc", first_pc, RESET_PC);

        // Backpressure: IBUF fills, requests stop, nothing lost on release.
        ds_allowin = 1'b0;
        repeat (10) step();
        chk("stall_req", last_req, 1'b0);
        chk("stall_valid", last_valid, 1'b1);
        bus.inst_sram_addr_ok = 1'b0; ds_allowin = 1'b1;
        base = n_deliv;
        repeat (8) step();
        chk("stall_drain", n_deliv - base, DEPTH);

        // Taken branch with two requests in flight.
        bus.inst_sram_addr_ok = 1'b1; dly_lo = 4; dly_hi = 4;
        for (int i = 0; i < 20 && q_addr.size() < 2; i++) step();
        chk("two_outstanding", q_addr.size(), 2);
        br_valid = 1'b1; br_taken = 1'b1; br_target = 32'hbfc00100;
        step();
        dly_lo = 0; dly_hi = 0;
        repeat (15) step();
        chk("br_first_pc", first_pc, 32'hbfc00100);

        // Exception beats a same-cycle taken branch.
        ex_flush = 1'b1; br_valid = 1'b1; br_taken = 1'b1; br_target = 32'hbfc00500;
        step();
        repeat (15) step();
        chk("ex_first_pc", first_pc, EX_ENTRY);

        // ERET to a misaligned address: one ADEL entry, no bus traffic.
        eret_flush = 1'b1; cp0_epc = 32'hbfc00042;
        step();
        base = n_deliv; base_acc = n_acc;
        repeat (15) step();
        chk("adel_noreq", n_acc - base_acc, 0);
        chk("adel_count", n_deliv - base, 1);
        chk("adel_first_pc", first_pc, 32'hbfc00042);
        chk("adel_first_exc", first_exc, ADEL);
        chk("adel_first_bad", first_bad, 32'hbfc00042);

        br_valid = 1'b1; br_taken = 1'b1; br_target = 32'hbfc00200;
        step();

        // Random bus timing, backpressure, stalls and redirects.
        dly_lo = 0; dly_hi = 5;
        base = n_deliv;
        for (int i = 0; i < 3000; i++) begin
            bus.inst_sram_addr_ok = ($urandom_range(0, 99) < 60);
            ds_allowin = ($urandom_range(0, 99) < 70);
            br_stall   = ($urandom_range(0, 99) < 10);
            r = int'($urandom_range(0, 99));
            if (r < 2) ex_flush = 1'b1;
            else if (r < 4) begin
                eret_flush = 1'b1;
                tmp = $urandom;
                cp0_epc = {16'hbfc1, tmp[15:2], ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00};
            end else if (r < 7) begin
                br_valid = 1'b1;
                br_taken = ($urandom_range(0, 2) != 0);
                tmp = $urandom;
                br_target = {16'hbfc2, tmp[15:2], 2'b00};
            end
            step();
        end
        chk("random_progress", (n_deliv - base > 200) ? 1 : 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit_mo.md
Name: fetch_unit_mo

Overview:
Parametrised successor to the single-request IF stage. Supports up to MAX_OUTSTANDING in-flight inst-SRAM requests, buffers returned instructions in an IBUF_DEPTH instruction buffer, and decouples fetch from decode backpressure. Handles redirects (branch, ERET, exception) by cancelling in-flight responses. Sits between the inst-SRAM-like bus and the ID stage.

Parameters:
RESET_PC, 32'hbfc00000, first fetch address after reset
EX_ENTRY, 32'hbfc00380, exception handler entry
MAX_OUTSTANDING, 2, max accepted-but-unreturned requests (1..4)
IBUF_DEPTH, 4, instruction buffer entries (power of 2, >= MAX_OUTSTANDING)

Ports:
clk  in  1  clock
resetn  in  1  async active-low reset
ds_allowin  in  1  ID can accept this cycle
br_valid  in  1  branch resolved in ID this cycle
br_taken  in  1  branch taken
br_target  in  32  taken target
br_stall  in  1  ID cannot resolve branch yet; hold new requests
ex_flush  in  1  exception committed in WB
eret_flush  in  1  ERET committed in WB
cp0_epc  in  32  ERET return address
fs_to_ds_valid  out  1  head of IBUF valid
fs_to_ds_pc  out  32  head PC
fs_to_ds_inst  out  32  head instruction (0 if ADEL)
fs_to_ds_excode  out  5  ADEL or NO_EX
fs_to_ds_badvaddr  out  32  faulting PC, else 0
inst_sram_req  out  1  request valid
inst_sram_wr  out  1  constant 0
inst_sram_size  out  2  constant 2'b10
inst_sram_wstrb  out  4  constant 0
inst_sram_addr  out  32  {fetch_pc[31:2],2'b00}
inst_sram_wdata  out  32  constant 0
inst_sram_addr_ok  in  1  request accepted
inst_sram_data_ok  in  1  response valid (in request order)
inst_sram_rdata  in  32  response data

Behaviour:
- Reset (resetn=0, async): fetch_pc=RESET_PC, outstanding=0, cancel_cnt=0, IBUF empty; all valid outputs 0, data outputs 0.
- Request issue: inst_sram_req = !br_stall && outstanding<MAX_OUTSTANDING && (ibuf_count+outstanding)<IBUF_DEPTH && fetch_pc[1:0]==0 && !redirect.
- req&&addr_ok: push fetch_pc into a pending-PC FIFO (depth MAX_OUTSTANDING), outstanding++, fetch_pc+=4 (wraps modulo 2^32).
- data_ok: pop pending-PC; if cancel_cnt>0, discard and cancel_cnt--; else enqueue {pc,rdata,NO_EX} to IBUF. outstanding--. Simultaneous addr_ok and data_ok: outstanding unchanged.
- Misaligned fetch_pc: no bus request; once outstanding==0 and IBUF not full, enqueue one {pc,0,ADEL,badvaddr=pc}, then stop fetching until redirect.
- Dequeue: fs_to_ds_valid = IBUF non-empty; pop when valid&&ds_allowin. Full IBUF with simultaneous pop and push is legal.
- Redirect priority: ex_flush > eret_flush > br_valid&&br_taken. Target is EX_ENTRY / cp0_epc / br_target. In the redirect cycle: fetch_pc<=target, IBUF cleared, cancel_cnt<=outstanding minus (data_ok this cycle ? 1 : 0), and no request issued. Not-taken br_valid has no effect.
- br_taken redirect clears only IBUF entries younger than the branch's delay slot. ID asserts br_valid only after the delay slot has been dequeued, so the whole IBUF is cleared.
- Latency: from addr_ok to fs_to_ds_valid is 1 cycle after data_ok (IBUF registered).

Optional Feature:
FETCH_PERF_CNT_EN: when defined, adds outputs perf_fetched[31:0] (instructions enqueued) and perf_bubble[31:0] (cycles ds_allowin=1 and IBUF empty), both reset to 0 and wrapping. When not defined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- mycpu.h holds ADEL, NO_EX, EX_ENTRY and the IBUF entry width (32+32+5+32).
- Natural sub-module: fetch_ibuf, a synchronous FIFO with flush, parametrised by width and depth, with push/pop/full/empty/count. It is instantiated for both the IBUF and the pending-PC FIFO.

Test Plan:
- Release reset; addr_ok always 1, data_ok 1 cycle later, ds_allowin=1 -> PCs bfc00000, bfc00004, bfc00008 delivered in order, one per cycle after warm-up.
- ds_allowin=0 for 10 cycles -> at most IBUF_DEPTH entries held, req drops; on release, no instruction lost or duplicated.
- Two requests outstanding (MAX_OUTSTANDING=2), br_taken target 0xbfc00100 -> both stale responses dropped; next delivered PC is bfc00100.
- ex_flush and br_taken in the same cycle -> next delivered PC is bfc00380.
- eret_flush with cp0_epc=0xbfc00042 -> one entry delivered with excode=ADEL, badvaddr=bfc00042, no bus request issued.
- Random addr_ok/data_ok delays (0-5 cycles) against a reference model -> delivered PC/inst sequence matches the model exactly.
